// File: rtl/uart_csr_bank_if.sv
// Bus-side register access signals for uart_csr_bank.
// The master modport drives addresses and strobes. The slave modport returns the read data.
interface uart_csr_bank_if;
    logic [15:0] bus2ip_addr_i;
    logic [15:0] bus2ip_data_i;
    logic        bus2ip_rd_ce_i;
    logic        bus2ip_wr_ce_i;
    logic [15:0] ip2bus_data_o;

    modport master (
        output bus2ip_addr_i, bus2ip_data_i, bus2ip_rd_ce_i, bus2ip_wr_ce_i,
        input  ip2bus_data_o
    );

    modport slave (
        input  bus2ip_addr_i, bus2ip_data_i, bus2ip_rd_ce_i, bus2ip_wr_ce_i,
        output ip2bus_data_o
    );
endinterface

// File: rtl/uart_csr_bank.sv
// Multi-channel UART control/status register bank: baud, framing, FIFO reset pulse,
// optional sticky interrupts (enabled by defining UART_CSR_IRQ_EN).
module uart_csr_bank #(
    parameter logic [3:0]  BASEADDR      = 4'h0,
    parameter int          NUM_CH        = 2,
    parameter logic [15:0] BAUD_RESET    = 16'd68,
    parameter int          RST_PULSE_LEN = 2
) (
    input  logic                  bus2ip_clk,
    input  logic                  bus2ip_rst_n,
    uart_csr_bank_if.slave        bus,
    input  logic [NUM_CH-1:0]     rx_buffer_data_present_i,
    input  logic [NUM_CH-1:0]     rx_buffer_full_i,
    input  logic [NUM_CH-1:0]     rx_buffer_hfull_i,
    input  logic [NUM_CH-1:0]     rx_buffer_afull_i,
    input  logic [NUM_CH-1:0]     rx_buffer_aempty_i,
    input  logic [NUM_CH-1:0]     tx_buffer_full_i,
    input  logic [NUM_CH-1:0]     tx_buffer_hfull_i,
    input  logic [NUM_CH-1:0]     tx_buffer_afull_i,
    input  logic [NUM_CH-1:0]     tx_buffer_aempty_i,
    output logic [NUM_CH-1:0]     parity_en_o,
    output logic [NUM_CH-1:0]     msb_first_o,
    output logic [NUM_CH-1:0]     start_polarity_o,
    output logic [NUM_CH-1:0]     reset_buffer_o,
    output logic [16*NUM_CH-1:0]  baud_config_o,
    output logic [NUM_CH-1:0]     irq_o
);
    localparam logic [7:0] OFF_BAUD     = 8'h00;
    localparam logic [7:0] OFF_CTRL     = 8'h01;
    localparam logic [7:0] OFF_FIFO_RST = 8'h02;
    localparam logic [7:0] OFF_STATUS   = 8'h03;
    localparam logic [7:0] OFF_INT_EN   = 8'h04;
    localparam logic [7:0] OFF_INT_STAT = 8'h05;
    localparam logic [7:0] OFF_IRQ_SUM  = 8'h00;
    localparam logic [7:0] OFF_VERSION  = 8'h01;
`ifdef UART_CSR_IRQ_EN
    localparam logic [15:0] VERSION = 16'h0200;
`else
    localparam logic [15:0] VERSION = 16'h0201;
`endif

    logic                 blk_sel;
    logic                 wr_en;
    logic [3:0]           ch_sel;
    logic [7:0]           reg_off;
    logic [15:0]          wdata;
    logic [16*NUM_CH-1:0] status_vec;
    logic [5*NUM_CH-1:0]  int_en_vec;
    logic [5*NUM_CH-1:0]  int_stat_vec;

    assign blk_sel = (bus.bus2ip_addr_i[15:12] == BASEADDR);
    assign ch_sel  = bus.bus2ip_addr_i[11:8];
    assign reg_off = bus.bus2ip_addr_i[7:0];
    assign wdata   = bus.bus2ip_data_i;
    assign wr_en   = bus.bus2ip_wr_ce_i && blk_sel;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [15:0] baud_reg;
        logic [2:0]  ctrl_reg;
        logic [3:0]  cnt_reg;
        logic        rst_buf_reg;
        logic        ch_wr;

        assign ch_wr = wr_en && (ch_sel == 4'(gi));

        // The pulse output is registered from cnt_reg, so the pulse starts one edge after the load.
        always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
            if (!bus2ip_rst_n) begin
                baud_reg    <= BAUD_RESET;
                ctrl_reg    <= 3'b000;
                cnt_reg     <= 4'd0;
                rst_buf_reg <= 1'b0;
            end else begin
                if (ch_wr && reg_off == OFF_BAUD) baud_reg <= wdata;
                if (ch_wr && reg_off == OFF_CTRL) ctrl_reg <= wdata[2:0];
                if (ch_wr && reg_off == OFF_FIFO_RST && wdata[0])
                    cnt_reg <= 4'(RST_PULSE_LEN);
                else if (cnt_reg != 4'd0)
                    cnt_reg <= cnt_reg - 4'd1;
                rst_buf_reg <= (cnt_reg != 4'd0);
            end
        end

        assign baud_config_o[16*gi +: 16] = baud_reg;
        assign parity_en_o[gi]      = ctrl_reg[2];
        assign msb_first_o[gi]      = ctrl_reg[1];
        assign start_polarity_o[gi] = ctrl_reg[0];
        assign reset_buffer_o[gi]   = rst_buf_reg;
        assign status_vec[16*gi +: 16] = {7'b0, rx_buffer_data_present_i[gi], rx_buffer_full_i[gi],
            rx_buffer_hfull_i[gi], rx_buffer_afull_i[gi], rx_buffer_aempty_i[gi], tx_buffer_full_i[gi],
            tx_buffer_hfull_i[gi], tx_buffer_afull_i[gi], tx_buffer_aempty_i[gi]};

`ifdef UART_CSR_IRQ_EN
        logic [4:0] int_en_reg;
        logic [4:0] int_stat_reg;
        logic [4:0] prev_reg;
        logic [4:0] src;
        logic [4:0] clr;
        logic       irq_reg;

        assign src = {tx_buffer_full_i[gi], tx_buffer_aempty_i[gi], rx_buffer_full_i[gi],
                      rx_buffer_hfull_i[gi], rx_buffer_data_present_i[gi]};

        always_comb begin
            clr = 5'b0;
            if (ch_wr && reg_off == OFF_INT_STAT)
                clr = wdata[4:0];
            else if (ch_wr && reg_off == OFF_FIFO_RST && wdata[1])
                clr = 5'b11111;
        end

        // Clear first, then OR in new rises, so a coincident set survives the clear.
        always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
            if (!bus2ip_rst_n) begin
                int_en_reg   <= 5'b0;
                int_stat_reg <= 5'b0;
                prev_reg     <= 5'b0;
                irq_reg      <= 1'b0;
            end else begin
                if (ch_wr && reg_off == OFF_INT_EN) int_en_reg <= wdata[4:0];
                int_stat_reg <= (int_stat_reg & ~clr) | (src & ~prev_reg);
                prev_reg     <= src;
                irq_reg      <= |(int_stat_reg & int_en_reg);
            end
        end

        assign int_en_vec[5*gi +: 5]   = int_en_reg;
        assign int_stat_vec[5*gi +: 5] = int_stat_reg;
        assign irq_o[gi]               = irq_reg;
`else
        assign int_en_vec[5*gi +: 5]   = 5'b0;
        assign int_stat_vec[5*gi +: 5] = 5'b0;
        assign irq_o[gi]               = 1'b0;
`endif
    end

    always_comb begin
        bus.ip2bus_data_o = 16'h0000;
        if (bus.bus2ip_rd_ce_i && blk_sel) begin
            if (ch_sel == 4'hF) begin
                case (reg_off)
`ifdef UART_CSR_IRQ_EN
                    OFF_IRQ_SUM: bus.ip2bus_data_o[NUM_CH-1:0] = irq_o;
`endif
                    OFF_VERSION: bus.ip2bus_data_o = VERSION;
                    default:     bus.ip2bus_data_o = 16'h0000;
                endcase
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_sel == 4'(c)) begin
                        case (reg_off)
                            OFF_BAUD:     bus.ip2bus_data_o = baud_config_o[16*c +: 16];
                            OFF_CTRL:     bus.ip2bus_data_o = {13'b0, parity_en_o[c], msb_first_o[c], start_polarity_o[c]};
                            OFF_STATUS:   bus.ip2bus_data_o = status_vec[16*c +: 16];
                            OFF_INT_EN:   bus.ip2bus_data_o = {11'b0, int_en_vec[5*c +: 5]};
                            OFF_INT_STAT: bus.ip2bus_data_o = {11'b0, int_stat_vec[5*c +: 5]};
                            default:      bus.ip2bus_data_o = 16'h0000;
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_csr_bank.sv
// Directed self-checking bench for uart_csr_bank (NUM_CH=2, default parameters).
module tb_uart_csr_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rx_dp = '0, rx_full = '0, rx_hfull = '0, rx_afull = '0, rx_aempty = '0;
    logic [1:0]  tx_full = '0, tx_hfull = '0, tx_afull = '0, tx_aempty = '0;
    logic [1:0]  parity_en, msb_first, start_pol, rst_buf, irq;
    logic [31:0] baud_cfg;
    logic [15:0] rd;
    int          n_total = 0;
    int          n_bad = 0;

`ifdef UART_CSR_IRQ_EN
    localparam logic [15:0] EXP_VERSION = 16'h0200;
`else
    localparam logic [15:0] EXP_VERSION = 16'h0201;
`endif

    uart_csr_bank_if bus_if ();

    uart_csr_bank #(.BASEADDR(4'h0), .NUM_CH(2), .BAUD_RESET(16'd68), .RST_PULSE_LEN(2)) dut (
        .bus2ip_clk               (clk),
        .bus2ip_rst_n             (rst_n),
        .bus                      (bus_if.slave),
        .rx_buffer_data_present_i (rx_dp),
        .rx_buffer_full_i         (rx_full),
        .rx_buffer_hfull_i        (rx_hfull),
        .rx_buffer_afull_i        (rx_afull),
        .rx_buffer_aempty_i       (rx_aempty),
        .tx_buffer_full_i         (tx_full),
        .tx_buffer_hfull_i        (tx_hfull),
        .tx_buffer_afull_i        (tx_afull),
        .tx_buffer_aempty_i       (tx_aempty),
        .parity_en_o              (parity_en),
        .msb_first_o              (msb_first),
        .start_polarity_o         (start_pol),
        .reset_buffer_o           (rst_buf),
        .baud_config_o            (baud_cfg),
        .irq_o                    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus_if.bus2ip_addr_i  = a;
        bus_if.bus2ip_data_i  = d;
        bus_if.bus2ip_wr_ce_i = 1'b1;
        @(posedge clk);
        #1 bus_if.bus2ip_wr_ce_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        bus_if.bus2ip_addr_i  = a;
        bus_if.bus2ip_rd_ce_i = 1'b1;
        #1 d = bus_if.ip2bus_data_o;
        bus_if.bus2ip_rd_ce_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.bus2ip_addr_i  = 16'h0;
        bus_if.bus2ip_data_i  = 16'h0;
        bus_if.bus2ip_rd_ce_i = 1'b0;
        bus_if.bus2ip_wr_ce_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_baud_out", baud_cfg, 32'h0044_0044);
        chk("rst_rst_buf", {30'b0, rst_buf}, 32'h0);
        chk("rst_ctrl_out", {26'b0, parity_en, msb_first, start_pol}, 32'h0);
        chk("rst_irq", {30'b0, irq}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Reset values over the bus
        bus_rd(16'h0000, rd); chk("baud0_rd", {16'b0, rd}, 32'h0044);
        bus_rd(16'h0100, rd); chk("baud1_rd", {16'b0, rd}, 32'h0044);
        bus_rd(16'h0001, rd); chk("ctrl0_rd", {16'b0, rd}, 32'h0);
        bus_rd(16'h0F01, rd); chk("version", {16'b0, rd}, {16'b0, EXP_VERSION});

        // Config writes to channel 1; channel 0 untouched
        bus_wr(16'h0100, 16'h1234);
        bus_wr(16'h0101, 16'h0005);
        chk("baud_cfg", baud_cfg, 32'h1234_0044);
        chk("parity_en", {30'b0, parity_en}, 32'h2);
        chk("msb_first", {30'b0, msb_first}, 32'h0);
        chk("start_pol", {30'b0, start_pol}, 32'h2);
        bus_rd(16'h0101, rd); chk("ctrl1_rd", {16'b0, rd}, 32'h5);
        bus_rd(16'h0200, rd); chk("unmapped_ch", {16'b0, rd}, 32'h0);
        bus_wr(16'h1000, 16'hFFFF);
        bus_rd(16'h0000, rd); chk("other_blk_wr", {16'b0, rd}, 32'h0044);
        bus_rd(16'h1100, rd); chk("other_blk_rd", {16'b0, rd}, 32'h0);
        @(negedge clk);
        bus_if.bus2ip_addr_i = 16'h0100;
        #1 chk("rd_ce_low", {16'b0, bus_if.ip2bus_data_o}, 32'h0);

        // Live STATUS on channel 1
        rx_full[1] = 1'b1; tx_aempty[1] = 1'b1;
        bus_rd(16'h0103, rd); chk("status1", {16'b0, rd}, 32'h0081);
        rx_full[1] = 1'b0; tx_aempty[1] = 1'b0;
        bus_rd(16'h0002, rd); chk("fifo_rst_rd", {16'b0, rd}, 32'h0);

        // Reset pulse: exactly 2 cycles starting at edge N+1
        bus_wr(16'h0002, 16'h0001);
        chk("pulse_n", {30'b0, rst_buf}, 32'h0);
        @(posedge clk); #1 chk("pulse_n1", {30'b0, rst_buf}, 32'h1);
        @(posedge clk); #1 chk("pulse_n2", {30'b0, rst_buf}, 32'h1);
        @(posedge clk); #1 chk("pulse_n3", {30'b0, rst_buf}, 32'h0);

        // Rewrite at N+1 extends the pulse to end at N+4
        bus_wr(16'h0002, 16'h0001);
        bus_wr(16'h0002, 16'h0001);
        chk("ext_n1", {30'b0, rst_buf}, 32'h1);
        @(posedge clk); #1 chk("ext_n2", {30'b0, rst_buf}, 32'h1);
        @(posedge clk); #1 chk("ext_n3", {30'b0, rst_buf}, 32'h1);
        @(posedge clk); #1 chk("ext_n4", {30'b0, rst_buf}, 32'h0);

`ifdef UART_CSR_IRQ_EN
        bus_wr(16'h0004, 16'h0001);
        bus_rd(16'h0004, rd); chk("int_en_rd", {16'b0, rd}, 32'h1);
        @(negedge clk) rx_dp[0] = 1'b1;
        @(posedge clk); #1 chk("irq_lat", {30'b0, irq}, 32'h0);
        bus_rd(16'h0005, rd); chk("int_stat_dp", {16'b0, rd}, 32'h1);
        @(posedge clk); #1 chk("irq_set", {30'b0, irq}, 32'h1);
        bus_rd(16'h0F00, rd); chk("irq_sum", {16'b0, rd}, 32'h1);
        bus_wr(16'h0005, 16'h0001);
        chk("irq_w1c_e", {30'b0, irq}, 32'h1);
        @(posedge clk); #1 chk("irq_w1c_e1", {30'b0, irq}, 32'h0);
        bus_rd(16'h0005, rd); chk("int_stat_clr", {16'b0, rd}, 32'h0);

        // Set wins over a coincident W1C
        @(negedge clk);
        tx_full[0] = 1'b1;
        bus_if.bus2ip_addr_i  = 16'h0005;
        bus_if.bus2ip_data_i  = 16'h0010;
        bus_if.bus2ip_wr_ce_i = 1'b1;
        @(posedge clk);
        #1 bus_if.bus2ip_wr_ce_i = 1'b0;
        bus_rd(16'h0005, rd); chk("set_wins", {16'b0, rd}, 32'h10);
        chk("irq_masked", {30'b0, irq}, 32'h0);
        bus_wr(16'h0004, 16'h0010);
        chk("int_en_e", {30'b0, irq}, 32'h0);
        @(posedge clk); #1 chk("int_en_e1", {30'b0, irq}, 32'h1);
        bus_wr(16'h0002, 16'h0002);
        @(posedge clk); #1 chk("fifo_clr_irq", {30'b0, irq}, 32'h0);
        bus_rd(16'h0005, rd); chk("fifo_clr_stat", {16'b0, rd}, 32'h0);
        chk("fifo_clr_nopulse", {30'b0, rst_buf}, 32'h0);
`else
        bus_wr(16'h0004, 16'h001F);
        bus_rd(16'h0004, rd); chk("int_en_off", {16'b0, rd}, 32'h0);
        @(negedge clk) rx_dp[0] = 1'b1; tx_full[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("irq_off", {30'b0, irq}, 32'h0);
        bus_rd(16'h0005, rd); chk("int_stat_off", {16'b0, rd}, 32'h0);
        bus_rd(16'h0F00, rd); chk("irq_sum_off", {16'b0, rd}, 32'h0);
`endif

        // Asynchronous reset in the middle of a pulse
        @(negedge clk) rx_dp = '0; tx_full = '0;
        bus_wr(16'h0002, 16'h0001);
        @(posedge clk); #1 chk("pre_arst_pulse", {30'b0, rst_buf}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pulse", {30'b0, rst_buf}, 32'h0);
        chk("arst_baud", baud_cfg, 32'h0044_0044);
        chk("arst_ctrl", {26'b0, parity_en, msb_first, start_pol}, 32'h0);
        chk("arst_irq", {30'b0, irq}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        bus_rd(16'h0100, rd); chk("arst_baud1_rd", {16'b0, rd}, 32'h0044);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
